// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer producing distance in cm; PONG_US_MEDIAN_EN adds a 3-sample median.
module ultrasonic_ranger #(
  parameter int CLK_PER_US = 65,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 25000,
  parameter int US_PER_CM  = 58,
  parameter int MAX_CM     = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] dist_cm,
  output logic       dist_valid,
  output logic       timeout
);
  localparam int CYC_PER_CM = CLK_PER_US * US_PER_CM;
  localparam int PW = $clog2(CLK_PER_US + 1);
  localparam int UW = $clog2(PERIOD_US + 1);
  localparam int CW = $clog2(CYC_PER_CM + 1);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_R, MEAS, HOLD} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic [UW-1:0] us;
  logic [CW-1:0] cyc;
  logic [8:0] cm, res_cm;
  logic res_v, res_to;
  logic echo_m, echo_s, echo_q;
  logic us_tick, rise, fall, expire;
  assign us_tick = pre == PW'(CLK_PER_US - 1);
  assign rise = echo_s & ~echo_q;
  assign fall = ~echo_s & echo_q;
  assign expire = us_tick && us == UW'(TRIG_US + TIMEOUT_US - 1);
  // two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {echo_m, echo_s, echo_q} <= 3'b000;
    else {echo_m, echo_s, echo_q} <= {echo, echo_m, echo_s};
  // microsecond prescaler, held in IDLE so trig rise aligns with a us boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else if (state != IDLE) pre <= us_tick ? '0 : pre + 1'b1;
  // measurement FSM; us counts microseconds since the last trig rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      trig   <= 1'b0;
      us     <= '0;
      cyc    <= '0;
      cm     <= '0;
      res_cm <= 9'(MAX_CM);
      res_to <= 1'b1;
      res_v  <= 1'b0;
    end else begin
      res_v <= 1'b0;
      if (us_tick) us <= us + 1'b1;
      case (state)
        IDLE: begin
          state <= TRIG;
          trig  <= 1'b1;
          us    <= '0;
        end
        TRIG: if (us_tick && us == UW'(TRIG_US - 1)) begin
          state <= WAIT_R;
          trig  <= 1'b0;
        end
        WAIT_R: if (expire) begin
          res_cm <= 9'(MAX_CM);
          res_to <= 1'b1;
          res_v  <= 1'b1;
          state  <= HOLD;
        end else if (rise) begin
          cyc   <= CW'(1);
          cm    <= '0;
          state <= MEAS;
        end
        MEAS: if (fall) begin
          res_cm <= cm;
          res_to <= 1'b0;
          res_v  <= 1'b1;
          state  <= HOLD;
        end else if (expire) begin
          res_cm <= 9'(MAX_CM);
          res_to <= 1'b1;
          res_v  <= 1'b1;
          state  <= HOLD;
        end else if (cyc == CW'(CYC_PER_CM - 1)) begin
          cyc <= '0;
          if (cm != 9'(MAX_CM)) cm <= cm + 9'd1;
        end else cyc <= cyc + 1'b1;
        HOLD: if (us_tick && us == UW'(PERIOD_US - 1)) begin
          state <= TRIG;
          trig  <= 1'b1;
          us    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef PONG_US_MEDIAN_EN
  logic [8:0] h0, h1, b, c, med;
  logic first;
  assign b = first ? res_cm : h0;
  assign c = first ? res_cm : h1;
  assign med = (res_cm > b) ? ((b > c) ? b : ((res_cm > c) ? c : res_cm))
                            : ((res_cm > c) ? res_cm : ((b > c) ? c : b));
  // history shift and median publish one cycle after each raw result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h0         <= '0;
      h1         <= '0;
      first      <= 1'b1;
      dist_cm    <= 9'(MAX_CM);
      timeout    <= 1'b1;
      dist_valid <= 1'b0;
    end else begin
      dist_valid <= res_v;
      if (res_v) begin
        h0      <= res_cm;
        h1      <= b;
        first   <= 1'b0;
        dist_cm <= med;
        timeout <= res_to;
      end
    end
`else
  assign dist_cm    = res_cm;
  assign timeout    = res_to;
  assign dist_valid = res_v;
`endif
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed checks of ultrasonic_ranger with scaled-down timing parameters.
module tb_ultrasonic_ranger;
  // 4 clk/us, 20 clk/cm, trig 40 clk, window ends 1040 clk after trig rise, period 2400 clk
`ifdef PONG_US_MEDIAN_EN
  localparam int LAT = 4, X = 1;
`else
  localparam int LAT = 3, X = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, echo = 1'b0;
  logic trig, dist_valid, timeout;
  logic [8:0] dist_cm;
  int total = 0, bad = 0, ncyc = 0, t_rise = 0;
  int hq[3];
  bit hfirst = 1'b1;

  ultrasonic_ranger #(.CLK_PER_US(4), .TRIG_US(10), .PERIOD_US(600), .TIMEOUT_US(250),
                      .US_PER_CM(5), .MAX_CM(40)) dut (
    .clk(clk), .rst_n(rst_n), .echo(echo), .trig(trig),
    .dist_cm(dist_cm), .dist_valid(dist_valid), .timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic int publish(input int raw);
`ifdef PONG_US_MEDIAN_EN
    int mx, mn;
    if (hfirst) begin
      hq = '{raw, raw, raw};
      hfirst = 1'b0;
    end else begin
      hq[2] = hq[1];
      hq[1] = hq[0];
      hq[0] = raw;
    end
    mx = hq[0]; mn = hq[0];
    for (int i = 1; i < 3; i++) begin
      if (hq[i] > mx) mx = hq[i];
      if (hq[i] < mn) mn = hq[i];
    end
    return hq[0] + hq[1] + hq[2] - mx - mn;
`else
    return raw;
`endif
  endfunction

  task automatic wait_until(input int target);
    while (ncyc < target) @(negedge clk);
  endtask

  task automatic wait_rise(output int t);
    for (int i = 0; i < 3000 && trig !== 1'b1; i++) @(negedge clk);
    if (trig !== 1'b1) begin
      total++; bad++;
      $display("FAIL trig_rise_wait: trig=%b required 1 within 3000 cycles", trig);
    end
    t = ncyc;
  endtask

  task automatic check_result(input string name, input int exp_cm, input logic exp_to);
    total++;
    if (dist_valid !== 1'b1 || dist_cm !== 9'(exp_cm) || timeout !== exp_to) begin
      bad++;
      $display("FAIL %s: valid=%b dist_cm=%0d timeout=%b required valid=1 dist_cm=%0d timeout=%b",
               name, dist_valid, dist_cm, timeout, exp_cm, exp_to);
    end
  endtask

  task automatic measure(input string name, input int delay, input int width, input int raw);
    int c0, e;
    wait_rise(c0);
    wait_until(c0 + 40);
    repeat (delay) @(negedge clk);
    echo = 1'b1;
    repeat (width) @(negedge clk);
    echo = 1'b0;
    e = publish(raw);
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (dist_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_early: valid=%b required 0 one cycle before latency", name, dist_valid);
    end
    @(negedge clk);
    check_result(name, e, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if (trig !== 1'b0 || dist_cm !== 9'd40 || dist_valid !== 1'b0 || timeout !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: trig=%b dist_cm=%0d valid=%b timeout=%b required 0/40/0/1",
               trig, dist_cm, dist_valid, timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    t_rise = ncyc;
    total++;
    if (trig !== 1'b1) begin
      bad++;
      $display("FAIL trig_first_cycle: trig=%b required 1", trig);
    end
  endtask

  task automatic test_trig_width;
    int n = 1;
    for (int i = 0; i < 100 && trig === 1'b1; i++) begin
      @(negedge clk);
      if (trig === 1'b1) n++;
    end
    total++;
    if (n != 40) begin
      bad++;
      $display("FAIL trig_width: got %0d cycles required 40", n);
    end
  endtask

  task automatic test_timeout;
    wait_until(t_rise + 1039 + X);
    total++;
    if (dist_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: valid=%b required 0", dist_valid);
    end
    @(negedge clk);
    check_result("timeout_no_echo", publish(40), 1'b1);
  endtask

  task automatic test_floor;
    measure("echo_10cm", 100, 200, 10);
    measure("echo_19cyc", 100, 19, 0);
    measure("echo_20cyc", 100, 20, 1);
  endtask

  task automatic test_saturate;
    int c0, strays = 0;
    measure("echo_saturate", 20, 920, 40);
    wait_rise(c0);
    wait_until(c0 + 60);
    echo = 1'b1;
    wait_until(c0 + 1039 + X);
    total++;
    if (dist_valid !== 1'b0) begin
      bad++;
      $display("FAIL window_early: valid=%b required 0", dist_valid);
    end
    @(negedge clk);
    check_result("echo_past_window", publish(40), 1'b1);
    repeat (20) @(negedge clk);
    echo = 1'b0;
    while (ncyc < c0 + 2400) begin
      @(negedge clk);
      if (dist_valid === 1'b1 && ncyc < c0 + 2400) strays++;
    end
    total++;
    if (strays != 0 || trig !== 1'b1) begin
      bad++;
      $display("FAIL single_valid_per_period: strays=%0d trig=%b required 0 and 1", strays, trig);
    end
  endtask

  task automatic test_back_to_back;
    int c0, c1, e;
    wait_rise(c0);
    wait_until(c0 + 10);
    echo = 1'b1;
    wait_until(c0 + 80);
    echo = 1'b0;
    repeat (200) @(negedge clk);
    echo = 1'b1;
    repeat (400) @(negedge clk);
    echo = 1'b0;
    e = publish(20);
    repeat (LAT) @(negedge clk);
    check_result("echo_high_at_entry", e, 1'b0);
    wait_rise(c1);
    total++;
    if (c1 - c0 != 2400) begin
      bad++;
      $display("FAIL trig_period: got %0d cycles required 2400", c1 - c0);
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    wait_rise(c0);
    wait_until(c0 + 60);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (trig !== 1'b0 || dist_cm !== 9'd40 || dist_valid !== 1'b0 || timeout !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_meas: trig=%b dist_cm=%0d valid=%b timeout=%b required 0/40/0/1",
               trig, dist_cm, dist_valid, timeout);
    end
    echo = 1'b0;
    hfirst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (dist_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_stray_valid: valid=%b required 0", dist_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (trig !== 1'b1 || dist_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_restart: trig=%b valid=%b required 1 and 0", trig, dist_valid);
    end
  endtask

  task automatic test_sequence;
    measure("seq_10", 100, 200, 10);
    measure("seq_30", 100, 600, 30);
    measure("seq_12", 100, 240, 12);
  endtask

  initial begin
    test_reset();
    test_trig_width();
    test_timeout();
    test_floor();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_sequence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
